// File: rtl/ofdm_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_pkg
//   Shared constants and types for the receive payload path.
//   - N_SC    : sub-carriers per OFDM symbol (taken from `N, default 512)
//   - GUARD   : samples discarded at each end of a symbol
//   - PAY_LEN : payload samples per symbol (N_SC - 2*GUARD)
//   - SYM_W   : width of symbol counter / configured symbol count
//   - SC_W    : width of the sub-carrier counter
//   - state_e : sequencer FSM encoding {IDLE, ARMED, RUN, DONE, ERR}
//   No ports (package).
// ----------------------------------------------------------------------------
`ifndef N
`define N 512
`endif

package ofdm_pkg;

    localparam int N_SC    = `N;
    localparam int GUARD   = 16;
    localparam int PAY_LEN = N_SC - 2 * GUARD;
    localparam int SYM_W   = 4;
    localparam int SC_W    = $clog2(N_SC);

    // Sized copies of the boundaries so comparisons stay width-matched.
    localparam logic [SC_W-1:0]  SC_ZERO      = '0;
    localparam logic [SC_W-1:0]  SC_ONE       = SC_W'(1);
    localparam logic [SC_W-1:0]  SC_MAX       = SC_W'(N_SC - 1);
    localparam logic [SC_W-1:0]  SC_PAY_FIRST = SC_W'(GUARD);
    localparam logic [SC_W-1:0]  SC_PAY_LAST  = SC_W'(N_SC - GUARD - 1);
    localparam logic [SYM_W-1:0] SYM_ZERO     = '0;
    localparam logic [SYM_W-1:0] SYM_ONE      = SYM_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // True when a sub-carrier position lies inside the payload window.
    function automatic logic in_payload(input logic [SC_W-1:0] sc);
        return (sc >= SC_PAY_FIRST) && (sc <= SC_PAY_LAST);
    endfunction

endpackage

// File: rtl/sc_sym_counter.sv
// ----------------------------------------------------------------------------
// sc_sym_counter
//   Sub-carrier counter (0..N_SC-1) cascaded into a symbol counter.
//   The sub-carrier counter advances on en_i and wraps N_SC-1 -> 0, bumping
//   the symbol counter on the wrap. clr_i (or rst_i) zeroes both.
// Ports
//   clk_i      in   1      clock
//   rst_i      in   1      synchronous active-high reset
//   clr_i      in   1      synchronous clear (new frame)
//   en_i       in   1      count one sample
//   last_sym_i in   SYM_W  index of the final symbol of the frame
//   sc_o       out  SC_W   current sub-carrier position (next sample's index)
//   sym_o      out  SYM_W  current symbol index
//   wrap_o     out  1      this enabled sample is the last of its symbol
//   last_o     out  1      position is the final sub-carrier of the final symbol
// ----------------------------------------------------------------------------
module sc_sym_counter
    import ofdm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SYM_W-1:0] last_sym_i,
    output logic [SC_W-1:0]  sc_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             wrap_o,
    output logic             last_o
);

    logic [SC_W-1:0]  sc_q;
    logic [SYM_W-1:0] sym_q;

    assign sc_o   = sc_q;
    assign sym_o  = sym_q;
    assign wrap_o = en_i && (sc_q == SC_MAX);
    // Not gated by en_i: the caller combines it with wrap_o.
    assign last_o = (sc_q == SC_MAX) && (sym_q == last_sym_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sc_q  <= SC_ZERO;
            sym_q <= SYM_ZERO;
        end else if (en_i) begin
            if (sc_q == SC_MAX) begin
                sc_q  <= SC_ZERO;
                // With a 15-symbol frame this reaches 15 only on the final
                // wrap, which is also the frame end, so it never overflows
                // inside a frame.
                sym_q <= sym_q + SYM_ONE;
            end else begin
                sc_q <= sc_q + SC_ONE;
            end
        end
    end

endmodule

// File: rtl/payload_sym_ctrl.sv
// ----------------------------------------------------------------------------
// payload_sym_ctrl
//   Frame-level sequencer for the receive payload path. Counts sub-carriers
//   and symbols on the FFT output stream and produces a registered select
//   strobe over the PAY_LEN payload samples of each symbol, stopping after
//   the configured number of symbols. Data is delayed one cycle outside this
//   block so it lines up with sel_vld.
//
//   Handshake: di_vld is a plain qualifier with no back-pressure. A sample is
//   consumed on every clock where di_vld=1 while the block is ARMED or RUN;
//   all outputs describe the sample consumed on the previous clock.
//
//   Build option: PAYLOAD_GAP_CHK_EN
//     defined   - a di_vld gap inside a symbol while running moves to ERR
//                 (err=1, busy=0, no frame_done); start or rst leaves ERR.
//     undefined - gaps pause the frame; err is tied 0; no ERR state.
//
// Ports
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      pulse: arm a new frame (accepted only in IDLE/ERR)
//   cfg_nsym   in   SYM_W  payload symbols per frame, sampled on accepted start
//   di_vld     in   1      input sample valid
//   sel_vld    out  1      previous sample is payload
//   sc_idx     out  SC_W   payload index of that sample (valid with sel_vld)
//   sym_idx    out  SYM_W  symbol index of that sample (valid with sel_vld)
//   sym_last   out  1      that sample is the last payload sample of its symbol
//   busy       out  1      high in ARMED/RUN
//   frame_done out  1      one-cycle pulse in the DONE cycle
//   err        out  1      sticky gap flag (0 unless PAYLOAD_GAP_CHK_EN)
//   dbg_state  out  3      current FSM state encoding (state_e)
// ----------------------------------------------------------------------------
module payload_sym_ctrl
    import ofdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SYM_W-1:0] cfg_nsym,
    input  logic             di_vld,
    output logic             sel_vld,
    output logic [SC_W-1:0]  sc_idx,
    output logic [SYM_W-1:0] sym_idx,
    output logic             sym_last,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    state_e           state_q;
    logic [SYM_W-1:0] nsym_q;
    logic             sel_vld_q;
    logic [SC_W-1:0]  sc_idx_q;
    logic [SYM_W-1:0] sym_idx_q;
    logic             sym_last_q;
    logic             busy_q;
    logic             frame_done_q;

    logic [SC_W-1:0]  sc_cnt;
    logic [SYM_W-1:0] sym_cnt;
    logic             cnt_wrap;
    logic             cnt_last;
    logic             cnt_en;
    logic             active;
    logic             start_ok;
    logic             frame_end;
    logic [SYM_W-1:0] last_sym;

    assign active    = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign cnt_en    = active && di_vld;
    assign frame_end = cnt_wrap && cnt_last;
    // Only meaningful while nsym_q >= 1, which holds whenever counting runs.
    assign last_sym  = nsym_q - SYM_ONE;

`ifdef PAYLOAD_GAP_CHK_EN
    logic err_q;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign err      = err_q;
`else
    assign start_ok = start && (state_q == ST_IDLE);
    assign err      = 1'b0;
`endif

    sc_sym_counter u_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (start_ok),
        .en_i       (cnt_en),
        .last_sym_i (last_sym),
        .sc_o       (sc_cnt),
        .sym_o      (sym_cnt),
        .wrap_o     (cnt_wrap),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nsym_q       <= SYM_ZERO;
            sel_vld_q    <= 1'b0;
            sc_idx_q     <= SC_ZERO;
            sym_idx_q    <= SYM_ZERO;
            sym_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PAYLOAD_GAP_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // Per-sample outputs: describe the sample consumed this clock.
            sel_vld_q    <= 1'b0;
            sym_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            if (cnt_en) begin
                sel_vld_q  <= in_payload(sc_cnt);
                sym_last_q <= (sc_cnt == SC_PAY_LAST);
                sc_idx_q   <= sc_cnt - SC_PAY_FIRST;
                sym_idx_q  <= sym_cnt;
            end

            if (start_ok) begin
                nsym_q <= cfg_nsym;
`ifdef PAYLOAD_GAP_CHK_EN
                err_q  <= 1'b0;
`endif
                if (cfg_nsym == SYM_ZERO) begin
                    // Empty frame: go straight to DONE and pulse frame_done.
                    state_q      <= ST_DONE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                end else begin
                    state_q <= ST_ARMED;
                    busy_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (di_vld) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (frame_end) begin
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
`ifdef PAYLOAD_GAP_CHK_EN
                        end else if (!di_vld && (sc_cnt != SC_ZERO)) begin
                            // Gap inside a symbol; gaps at a symbol boundary
                            // (sc_cnt == 0) are allowed.
                            state_q <= ST_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
`endif
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
`ifdef PAYLOAD_GAP_CHK_EN
                    ST_ERR: begin
                        // Held until start (handled above) or rst.
                        state_q <= ST_ERR;
                    end
`endif
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel_vld    = sel_vld_q;
    assign sc_idx     = sc_idx_q;
    assign sym_idx    = sym_idx_q;
    assign sym_last   = sym_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule
